// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: text-mode controller for a 40x24 character VGA terminal.
//
// Display side: turns the timing generator's (h_cnt, v_cnt) into a video-RAM
// read address, substitutes the blinking cursor glyph, and feeds the font ROM
// with character/pixel/line.
// Everything is pipeline-aligned so that pix_out and de_out appear 3 cycles
// after the pixel position was presented.
// The screen scrolls through a circular top-row pointer: logical row r lives in
// physical row (top_row + r) mod ROWS.
//
// Write side: accepts terminal characters (char_in/char_valid/char_ready) and
// handles printable writes, CR, auto-wrap and scroll. Scrolling clears the new
// bottom line, and clear_req clears the whole screen. All video-RAM writes are
// one cell per cycle.
//
// Ports:
//   clk, rst                      pixel clock, synchronous active-high reset
//   h_cnt, v_cnt, active          pixel position / visible-area flag
//   frame_tick                    one pulse per frame (cursor blink timebase)
//   vram_raddr, vram_rdata        display read port (sync RAM, 1-cycle latency)
//   font_character/pixel/line     font ROM inputs
//   font_out                      font ROM pixel (1-cycle latency)
//   pix_out, de_out               final pixel and its data-enable
//   vram_waddr/wdata/we           video-RAM write port
//   char_in, char_valid           ASCII character from terminal
//   char_ready                    character accepted this cycle when valid
//   clear_req                     pulse: clear the whole screen
module vga_text_ctrl #(
    parameter int COLS         = 40,
    parameter int ROWS         = 24,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       active,
    input  logic       frame_tick,
    output logic [9:0] vram_raddr,
    input  logic [5:0] vram_rdata,
    output logic [5:0] font_character,
    output logic [3:0] font_pixel,
    output logic [4:0] font_line,
    input  logic       font_out,
    output logic       pix_out,
    output logic       de_out,
    output logic [9:0] vram_waddr,
    output logic [5:0] vram_wdata,
    output logic       vram_we,
    input  logic [6:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear_req
);

    localparam int FONT_H = 20;
    localparam int CELLS  = COLS * ROWS;
    localparam int BW     = $clog2(BLINK_FRAMES + 1);
    localparam int STAGES = 3;

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;

    state_t     state, state_n;
    logic [5:0] cur_col, cur_col_n;
    logic [4:0] cur_row, cur_row_n;
    logic [4:0] top_row, top_row_n;
    logic [9:0] cnt, cnt_n;
    logic       clear_pend, clear_pend_n;
    logic [5:0] wcode, wcode_n;
    logic [BW-1:0] blink_cnt;
    logic       blink_ph;

    // ---------------- display pipeline ----------------
    logic [5:0] d_col, d_lrow;
    logic [4:0] d_line, d_prow;
    logic [6:0] d_sum;
    logic [4:0] line_s1;
    logic [3:0] pix_s1;
    logic       hit_s1, hit_s2;
    logic [STAGES:1] vld_pipe;

    always_comb begin
        d_col  = h_cnt[9:4];
        d_lrow = 6'(v_cnt / 10'(FONT_H));
        d_line = 5'(v_cnt % 10'(FONT_H));
        // lrow can exceed ROWS during blanking, so use a true modulo here
        d_sum  = 7'(top_row) + 7'(d_lrow);
        d_prow = 5'(d_sum % 7'(ROWS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_raddr <= '0;
            line_s1    <= '0;
            pix_s1     <= '0;
            hit_s1     <= 1'b0;
            hit_s2     <= 1'b0;
            font_line  <= '0;
            font_pixel <= '0;
            vld_pipe   <= '0;
        end else begin
            vram_raddr <= 10'(d_prow) * 10'(COLS) + 10'(d_col);
            line_s1    <= d_line;
            pix_s1     <= h_cnt[3:0];
            // cursor compare is in logical coordinates, independent of scroll
            hit_s1     <= blink_ph && (d_col == cur_col) && (d_lrow == 6'(cur_row));
            hit_s2     <= hit_s1;
            font_line  <= line_s1;
            font_pixel <= pix_s1;
            vld_pipe   <= {vld_pipe[STAGES-1:1], active};
        end
    end

    // RAM data arrives in stage 2, so the cursor mux sits after the RAM
    assign font_character = (rst || hit_s2) ? 6'h00 : vram_rdata;
    assign de_out         = vld_pipe[STAGES];
    assign pix_out        = font_out & de_out & ~rst;

    // ---------------- cursor blink ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- write FSM ----------------
    logic [5:0] w_sum;
    logic [4:0] w_prow;
    logic [9:0] w_base;
    logic       newline;

    always_comb begin
        w_sum  = 6'(top_row) + 6'(cur_row);
        w_prow = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : 5'(w_sum);
        w_base = 10'(w_prow) * 10'(COLS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLR_ALL;
            cur_col    <= '0;
            cur_row    <= '0;
            top_row    <= '0;
            cnt        <= '0;
            clear_pend <= 1'b0;
            wcode      <= '0;
        end else begin
            state      <= state_n;
            cur_col    <= cur_col_n;
            cur_row    <= cur_row_n;
            top_row    <= top_row_n;
            cnt        <= cnt_n;
            clear_pend <= clear_pend_n;
            wcode      <= wcode_n;
        end
    end

    always_comb begin
        state_n      = state;
        cur_col_n    = cur_col;
        cur_row_n    = cur_row;
        top_row_n    = top_row;
        cnt_n        = cnt;
        wcode_n      = wcode;
        // a request arriving during a full clear is absorbed by that clear
        clear_pend_n = clear_pend | (clear_req & (state != CLR_ALL));
        newline      = 1'b0;
        vram_we      = 1'b0;
        vram_waddr   = '0;
        vram_wdata   = '0;
        char_ready   = 1'b0;

        case (state)
            IDLE: begin
                char_ready = ~clear_pend & ~clear_req;
                if (clear_pend | clear_req) begin
                    state_n      = CLR_ALL;
                    cnt_n        = '0;
                    clear_pend_n = 1'b0;
                end else if (char_valid) begin
                    if (char_in == 7'h0D) begin
                        newline = 1'b1;
                    end else if (char_in >= 7'h20 && char_in <= 7'h5F) begin
                        wcode_n = char_in[5:0];
                        state_n = WRITE;
                    end else if (char_in >= 7'h60) begin
                        wcode_n = 6'(char_in - 7'h20);
                        state_n = WRITE;
                    end
                    // anything else is swallowed without effect
                end
            end
            WRITE: begin
                vram_we    = 1'b1;
                vram_waddr = w_base + 10'(cur_col);
                vram_wdata = wcode;
                if (cur_col < 6'(COLS - 1)) begin
                    cur_col_n = cur_col + 1'b1;
                    state_n   = IDLE;
                end else begin
                    newline = 1'b1;
                end
            end
            CLR_LINE: begin
                // top_row already advanced, so w_base is the new bottom row
                vram_we    = 1'b1;
                vram_waddr = w_base + cnt;
                vram_wdata = 6'h20;
                if (cnt == 10'(COLS - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CLR_ALL: begin
                vram_we    = 1'b1;
                vram_waddr = cnt;
                vram_wdata = 6'h20;
                if (cnt == 10'(CELLS - 1)) begin
                    cnt_n     = '0;
                    cur_col_n = '0;
                    cur_row_n = '0;
                    top_row_n = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = CLR_ALL;
        endcase

        if (newline) begin
            cur_col_n = '0;
            if (cur_row < 5'(ROWS - 1)) begin
                cur_row_n = cur_row + 1'b1;
                state_n   = IDLE;
            end else begin
                top_row_n = (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 1'b1;
                cnt_n     = '0;
                state_n   = CLR_LINE;
            end
        end

        if (rst) begin
            vram_we    = 1'b0;
            vram_waddr = '0;
            vram_wdata = '0;
            char_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Testbench for vga_text_ctrl: models the sync video RAM and a font ROM.
// Expected writes and expected display samples are queued by the stimulus and
// checked by independent monitors.
module tb_vga_text_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_cnt, v_cnt;
    logic       active, frame_tick;
    logic [9:0] vram_raddr;
    logic [5:0] vram_rdata;
    logic [5:0] font_character;
    logic [3:0] font_pixel;
    logic [4:0] font_line;
    logic       font_out;
    logic       pix_out, de_out;
    logic [9:0] vram_waddr;
    logic [5:0] vram_wdata;
    logic       vram_we;
    logic [6:0] char_in;
    logic       char_valid, char_ready, clear_req;

    vga_text_ctrl dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
        .frame_tick(frame_tick), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
        .font_character(font_character), .font_pixel(font_pixel),
        .font_line(font_line), .font_out(font_out), .pix_out(pix_out),
        .de_out(de_out), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .clear_req(clear_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [9:0] addr; logic [5:0] data;} wr_t;
    typedef struct packed {
        logic [9:0] addr; logic [5:0] ch; logic [3:0] pix; logic [4:0] line;
        logic de; logic po;
    } dp_t;

    wr_t wq[$];
    dp_t dq[$];
    wr_t me;
    dp_t md;
    int  tot = 0;
    int  bad = 0;
    logic [5:0] mem [0:1023];
    logic       probe_now = 1'b0;
    logic [2:0] probe_sr  = 3'b000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // video RAM, font ROM (pixel = xor of lsbs), probe stage tracker
    always @(posedge clk) begin
        if (vram_we) mem[vram_waddr] <= vram_wdata;
        vram_rdata <= mem[vram_raddr];
        font_out   <= font_character[0] ^ font_pixel[0] ^ font_line[0];
        probe_sr   <= {probe_sr[1:0], probe_now};
    end

    // monitors
    always @(negedge clk) begin
        if (!rst && vram_we) begin
            if (wq.size() == 0) begin
                tot++; bad++;
                $display("FAIL wr_extra: got write addr=%0d data=%0h want none", vram_waddr, vram_wdata);
            end else begin
                me = wq.pop_front();
                chk("wr_addr", 32'(vram_waddr), 32'(me.addr));
                chk("wr_data", 32'(vram_wdata), 32'(me.data));
            end
        end
        if (dq.size() > 0) begin
            md = dq[0];
            if (probe_sr[0]) chk("disp_raddr", 32'(vram_raddr), 32'(md.addr));
            if (probe_sr[1]) begin
                chk("disp_char", 32'(font_character), 32'(md.ch));
                chk("disp_pix",  32'(font_pixel),     32'(md.pix));
                chk("disp_line", 32'(font_line),      32'(md.line));
            end
            if (probe_sr[2]) begin
                chk("disp_de",   32'(de_out),  32'(md.de));
                chk("disp_pout", 32'(pix_out), 32'(md.po));
                void'(dq.pop_front());
            end
        end
    end

    task automatic push_wr(input int a, input logic [5:0] d);
        wr_t e;
        e.addr = 10'(a);
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            tot++; bad++;
            $display("FAIL ready_timeout: got ready=0 want 1");
        end
    endtask

    task automatic send(input logic [6:0] ch);
        wait_ready();
        char_in    = ch;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic put(input logic [6:0] ch, input int a, input logic [5:0] d);
        push_wr(a, d);
        send(ch);
    endtask

    task automatic drain();
        int n = 0;
        while (wq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(wq.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic probe(input int h, input int v, input logic act, input int a,
                         input logic [5:0] ch, input int px, input int ln, input logic po);
        dp_t e;
        e.addr = 10'(a); e.ch = ch; e.pix = 4'(px); e.line = 5'(ln);
        e.de = act; e.po = po;
        dq.push_back(e);
        h_cnt = 10'(h); v_cnt = 10'(v); active = act; probe_now = 1'b1;
        @(posedge clk); #1;
        probe_now = 1'b0; active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] tc [8] = '{7'h20, 7'h5F, 7'h60, 7'h7A, 7'h7F, 7'h30, 7'h5A, 7'h21};
    logic [5:0] td [8] = '{6'h20, 6'h1F, 6'h00, 6'h1A, 6'h1F, 6'h30, 6'h1A, 6'h21};

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; h_cnt = '0; v_cnt = '0; active = 1'b0; frame_tick = 1'b0;
        char_in = '0; char_valid = 1'b0; clear_req = 1'b0; vram_rdata = '0; font_out = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 6'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we",    32'(vram_we),    0);
        chk("rst_ready", 32'(char_ready), 0);
        chk("rst_de",    32'(de_out),     0);
        chk("rst_raddr", 32'(vram_raddr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // power-up clear: 960 cycles not ready, writes 0..959 of space
        for (int i = 0; i < 960; i++) push_wr(i, 6'h20);
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("clr_len", 32'(n), 960);
        drain();

        // 'A' and 'a' both map to code 01; one busy cycle after each accept
        put(7'h41, 0, 6'h01);
        @(negedge clk); chk("busy_A", 32'(char_ready), 0);
        @(negedge clk); chk("back_A", 32'(char_ready), 1);
        put(7'h61, 1, 6'h01);
        @(negedge clk); chk("busy_a", 32'(char_ready), 0);
        @(negedge clk); chk("back_a", 32'(char_ready), 1);

        // non-printables are swallowed: no write, ready stays up
        send(7'h07);
        @(negedge clk); chk("bel_ready", 32'(char_ready), 1);
        send(7'h0A);
        send(7'h1F);
        send(7'h00);

        // fill the rest of row 0; the 40th char lands at 39 and wraps
        for (int i = 0; i < 38; i++) put(tc[i % 8], 2 + i, td[i % 8]);
        put(7'h42, 40, 6'h02);               // cursor now (1,1)
        send(7'h0D);                         // (0,2)
        repeat (21) send(7'h0D);             // (0,23)
        put(7'h43, 920, 6'h03);              // (1,23)
        for (int i = 0; i < 40; i++) push_wr(i, 6'h20);
        send(7'h0D);                         // scroll: top_row=1, clear phys row 0
        drain();

        // after scroll logical row 0 reads physical row 1
        probe(0, 0, 1'b0, 40, 6'h02, 0, 0, 1'b0);
        // cursor at logical (0,23) -> physical row 0, shown as '@'
        probe(1, 460, 1'b1, 0, 6'h00, 1, 0, 1'b1);

        put(7'h44, 0, 6'h04);                // cursor (1,23)
        // next scroll clears physical row 1; clear_req mid-line waits for it
        for (int i = 0; i < 40; i++) push_wr(40 + i, 6'h20);
        for (int i = 0; i < 960; i++) push_wr(i, 6'h20);
        send(7'h0D);
        repeat (8) @(posedge clk);
        #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        @(negedge clk); chk("clr_busy", 32'(char_ready), 0);
        drain();

        put(7'h45, 0, 6'h05);                // cursor back at (0,0)
        send(7'h0D);
        send(7'h0D);
        put(7'h20, 80, 6'h20);
        put(7'h20, 81, 6'h20);
        put(7'h20, 82, 6'h20);
        put(7'h54, 83, 6'h14);               // cell (3,2), cursor (4,2)
        drain();

        probe(53, 45, 1'b1, 83, 6'h14, 5, 5, 1'b0);

        // blink: shown for 30 ticks, hidden for 30
        ticks(29);
        probe(66, 41, 1'b1, 84, 6'h00, 2, 1, 1'b1);
        ticks(1);
        probe(66, 41, 1'b1, 84, 6'h20, 2, 1, 1'b1);
        ticks(29);
        probe(66, 41, 1'b1, 84, 6'h20, 2, 1, 1'b1);
        ticks(1);
        probe(66, 41, 1'b1, 84, 6'h00, 2, 1, 1'b1);

        drain();
        chk("disp_left", 32'(dq.size()), 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Text-mode controller for the 40x24 VGA terminal. It sequences the font ROM path each pixel: it computes the video-RAM read address, applies cursor substitution, and drives the ROM's character, pixel and line inputs with pipeline-aligned data-enable. It also owns the write side of video RAM. That covers terminal character writes, carriage return, auto-wrap, hardware scroll via a circular top-row pointer, and full-screen clear.

Parameters:
COLS, 40, characters per row
ROWS, 24, character rows
BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
h_cnt  in  10  horizontal pixel position from timing gen
v_cnt  in  10  vertical line position from timing gen
active  in  1  h_cnt/v_cnt inside 640x480 visible area
frame_tick  in  1  one-cycle pulse per frame
vram_raddr  out  10  display read address
vram_rdata  in  6  character code; sync RAM, valid 1 cycle after address
font_character  out  6  to font ROM
font_pixel  out  4  to font ROM
font_line  out  5  to font ROM
font_out  in  1  font ROM pixel; 1 cycle after its inputs
pix_out  out  1  final pixel, gated by de_out
de_out  out  1  active, delayed to align with pix_out
vram_waddr  out  10  write address
vram_wdata  out  6  write data
vram_we  out  1  write strobe
char_in  in  7  ASCII from terminal/PIA
char_valid  in  1  char_in valid
char_ready  out  1  controller accepts char this cycle
clear_req  in  1  pulse: clear screen

Behaviour:
- Reset: state->CLR_ALL, cursor (col,row)=(0,0), top_row=0, blink counter 0, blink phase=1 (cursor shown). All outputs 0 and char_ready=0 while rst is high.
- Display pipeline, inputs sampled at cycle t:
  - col=h_cnt[9:4]; lrow=v_cnt/20; line=v_cnt mod 20.
  - prow=(top_row+lrow) mod 24.
  - vram_raddr = prow*40+col is registered at t+1.
  - font_character and font_line/font_pixel (h_cnt[3:0]), delayed 2 stages, are valid at t+2.
  - pix_out=font_out&de_out, with de_out=active delayed 3 cycles.
  - Total latency is 3 cycles.
- Cursor substitution: if the cell (col,lrow) equals cursor (col,row) and blink phase=1, font_character=6'h00 ('@') in place of vram_rdata.
- Blink: counts frame_tick. At BLINK_FRAMES-1 it wraps to 0 and toggles phase.
- Write FSM states: IDLE, WRITE, CLR_LINE, CLR_ALL.
  - char_ready = (state==IDLE) & !clear_pend & !clear_req.
  - Accept occurs on char_valid&char_ready.
- Char mapping:
  - 0x0D = CR.
  - 0x20-0x5F -> code=char_in[5:0].
  - 0x60-0x7F -> fold to uppercase (minus 0x20), then [5:0].
  - All else is consumed and ignored: no write, no cursor move.
- Printable: IDLE->WRITE. In WRITE, vram_we=1 for exactly one cycle, waddr=prow(row)*40+col.
  - If col<39: col++ and go to IDLE; ready again at accept+2.
  - If col==39: newline.
- Newline (CR, or wrap after col 39): col=0.
  - If row<23: row++ and go to IDLE.
  - Else row stays 23, top_row=(top_row+1) mod 24, then CLR_LINE.
- CLR_LINE: writes code 0x20 (space) to the 40 cells of the new physical bottom row. One write per cycle, col 0..39 in order, then IDLE.
- CLR_ALL: writes 0x20 to addresses 0..959 ascending, one per cycle. Then cursor=(0,0), top_row=0, IDLE.
- clear_req:
  - Sets clear_pend (sticky); IDLE moves to CLR_ALL next cycle.
  - If it arrives mid WRITE/CLR_LINE, the current operation completes first, then CLR_ALL.
  - If it arrives during CLR_ALL, the clear is not restarted; clear_pend is cleared on entry to CLR_ALL.
- Reset mid-operation: aborts immediately and restarts CLR_ALL. Partial writes are permitted.
- Address arithmetic: 10-bit, max 959. top_row and row wrap mod 24, never 24.

Test Plan:
- Reset release -> char_ready=0 for exactly 960 cycles; vram_we=1 with waddr 0..959 and wdata 0x20; then char_ready=1, cursor (0,0).
- Send 'A'(0x41) then 'a'(0x61) -> writes 0x01 at addr 0 and addr 1; cursor (2,0); each accept followed by ready=0 for 1 cycle.
- Send 40 printables on row 0 -> 40th written at addr 39, cursor (0,1); 0x07 (BEL) -> no write, cursor unchanged.
- Cursor at row 23, send CR -> top_row=1; 40 writes of 0x20 at addr 0..39; display lrow 0 now reads addr 40..79; cursor (0,23).
- Display: place 0x14 at cell (3,2) with top_row=0; h_cnt=53, v_cnt=45, active=1 -> vram_raddr=83 at t+1; font_character=0x14, font_pixel=5, font_line=5 at t+2; de_out=1 at t+3.
- Blink: cursor cell shows code 0x00 for 30 frame_ticks, then vram data for 30; clear_req during CLR_LINE -> CLR_LINE finishes, then 960-cycle clear, cursor (0,0).
